// File: rtl/instruction_fetch.sv
// Instruction fetch unit: one outstanding imem read, 2-entry instruction FIFO, redirect flush.
// Optional FETCH_MISALIGN_EXC_EN traps misaligned redirect targets instead of silently aligning them.
//
// state   | meaning
// FETCH   | may issue a read at pc
// WAIT    | read outstanding, its word will be pushed
// DISCARD | read outstanding, its word will be dropped
// TRAP    | halted on misaligned redirect target
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic        exc_misaligned,
   output logic [31:0] exc_pc
);

   localparam logic [1:0]  ST_FETCH   = 2'd0;
   localparam logic [1:0]  ST_WAIT    = 2'd1;
   localparam logic [1:0]  ST_DISCARD = 2'd2;
   localparam logic [1:0]  ST_TRAP    = 2'd3;
   localparam logic [31:0] NOP        = 32'h0000_0013;

   logic [1:0]  state, state_nxt;
   logic [31:0] pc;
   logic [31:0] redirect_target;
   logic        redirect_mis;
   logic        trap_drop;
   logic        trap_drop_nxt;

   logic [31:0] fifo_inst [2];
   logic [31:0] fifo_pc   [2];
   logic        rd_ptr, wr_ptr;
   logic [1:0]  count;
   logic [31:0] last_inst, last_pc;
   logic        push, pop;

`ifdef FETCH_MISALIGN_EXC_EN
   assign redirect_mis    = redirect && (redirect_pc[1:0] != 2'b00);
   assign redirect_target = redirect_pc;
`else
   assign redirect_mis    = 1'b0;
   assign redirect_target = redirect_pc & ~32'h3;
`endif

   assign imem_req   = !reset && (state == ST_FETCH) && !redirect && (count < 2'd2);
   assign imem_addr  = pc;
   assign push       = (state == ST_WAIT) && imem_rvalid && !redirect;
   assign inst_valid = (count != 2'd0);
   assign pop        = inst_valid && inst_ready;
   assign inst       = inst_valid ? fifo_inst[rd_ptr] : last_inst;
   assign inst_pc    = inst_valid ? fifo_pc[rd_ptr]   : last_pc;

   always_comb begin
      state_nxt = state;
      if (redirect) begin
         case (state)
            ST_WAIT:    state_nxt = imem_rvalid ? ST_FETCH : ST_DISCARD;
            ST_DISCARD: state_nxt = imem_rvalid ? ST_FETCH : ST_DISCARD;
            // a read abandoned on the way into TRAP must still be swallowed after leaving it
            ST_TRAP:    state_nxt = (trap_drop && !imem_rvalid) ? ST_DISCARD : ST_FETCH;
            default:    state_nxt = ST_FETCH;
         endcase
         if (redirect_mis) state_nxt = ST_TRAP;
      end else begin
         case (state)
            ST_FETCH:   if (imem_req && imem_gnt) state_nxt = ST_WAIT;
            ST_WAIT:    if (imem_rvalid) state_nxt = ST_FETCH;
            ST_DISCARD: if (imem_rvalid) state_nxt = ST_FETCH;
            default:    state_nxt = state;
         endcase
      end
   end

   always_comb begin
      trap_drop_nxt = 1'b0;
      if (state_nxt == ST_TRAP && !imem_rvalid) begin
         trap_drop_nxt = (state == ST_WAIT) || (state == ST_DISCARD) ||
                         ((state == ST_TRAP) && trap_drop);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_FETCH;
         pc        <= RESET_PC;
         trap_drop <= 1'b0;
         rd_ptr    <= 1'b0;
         wr_ptr    <= 1'b0;
         count     <= 2'd0;
         last_inst <= NOP;
         last_pc   <= 32'h0;
      end else begin
         state     <= state_nxt;
         trap_drop <= trap_drop_nxt;
         if (redirect)
            pc <= redirect_target;
         else if (imem_req && imem_gnt)
            pc <= pc + 32'd4;
         if (pop) begin
            last_inst <= fifo_inst[rd_ptr];
            last_pc   <= fifo_pc[rd_ptr];
         end
         if (redirect) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
         end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
         end
      end
   end

   // pc has already advanced past the granted word when its data returns
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_inst[wr_ptr] <= imem_rdata;
         fifo_pc[wr_ptr]   <= pc - 32'd4;
      end
   end

`ifdef FETCH_MISALIGN_EXC_EN
   logic        exc_mis_q;
   logic [31:0] exc_pc_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         exc_mis_q <= 1'b0;
         exc_pc_q  <= 32'h0;
      end else if (redirect) begin
         exc_mis_q <= redirect_mis;
         exc_pc_q  <= redirect_mis ? redirect_pc : 32'h0;
      end
   end

   assign exc_misaligned = exc_mis_q;
   assign exc_pc         = exc_pc_q;
`else
   assign exc_misaligned = 1'b0;
   assign exc_pc         = 32'h0;
`endif

endmodule
